// File: rtl/mbu_param.sv
// Memory bank unit: NREGS bank registers driving the address extension bus.
// CU and I/O access, auto-index latch, bank increment and MBP shadow.
module mbu_param #(
   parameter int NREGS = 8,
   parameter int BANKW = 8,
   parameter int IDXW  = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             nreset,
   input  logic             nfpram_rom,
   input  logic             nwmbp,
   input  logic             nrmbp,
   input  logic             nwar,
   input  logic [1:0]       waddr,
   input  logic             nir_idx,
   input  logic             t34,
   input  logic [IDXW-1:0]  ir,
   input  logic [BANKW-1:0] ibus_in,
   output logic [BANKW-1:0] ibus_out,
   output logic             ibus_oe,
   input  logic             niombr,
   input  logic [IDXW-1:0]  io_addr,
   input  logic             nr,
   input  logic             nw,
   input  logic [BANKW-1:0] db_in,
   output logic [BANKW-1:0] db_out,
   output logic             db_oe,
   input  logic             nbinc,
   input  logic             nsave,
   input  logic             nrestore,
   output logic [BANKW-1:0] aext,
   output logic             nen,
   output logic             bovf
);

   logic [BANKW-1:0] regs [NREGS];
   logic [BANKW-1:0] shadow;
   logic             nw_q;
   logic             idx_lat;
   logic [IDXW-1:0]  ridx;
   logic             io_wr;
   logic             inc_win;
   logic [BANKW:0]   inc_sum;

   // Select the register that currently drives aext
   always_comb begin
      ridx = io_addr;
      if (!nrmbp)
         ridx = '0;
      else if (!nwar)
         ridx = (idx_lat && waddr == 2'd3) ? ir : IDXW'(waddr);
   end

   // Write strobes, increment arbitration and bus outputs
   always_comb begin
      io_wr   = !niombr && !nw && nw_q;
      inc_sum = {1'b0, regs[ridx]} + {{BANKW{1'b0}}, 1'b1};
      inc_win = !nbinc;
      if (ridx == '0 && (!nwmbp || !nrestore))
         inc_win = 1'b0;
      if (io_wr && io_addr == ridx)
         inc_win = 1'b0;
      if (nen)
         aext = {nfpram_rom, {(BANKW-1){1'b0}}};
      else
         aext = regs[ridx];
      ibus_out = aext;
      ibus_oe  = !nrmbp;
      db_out   = aext;
      db_oe    = !niombr && !nr;
   end

   // Register file updates; later assignments take priority
   always_ff @(posedge clk) begin
      if (!nreset) begin
         for (int i = 0; i < NREGS; i++)
            regs[i] <= '0;
         shadow  <= '0;
         nen     <= 1'b1;
         bovf    <= 1'b0;
         nw_q    <= 1'b1;
         idx_lat <= 1'b0;
      end else begin
         if (inc_win) begin
            regs[ridx] <= inc_sum[BANKW-1:0];
            bovf       <= inc_sum[BANKW];
         end
         if (!nrestore)
            regs[0] <= shadow;
         if (io_wr) begin
            regs[io_addr] <= db_in;
            nen           <= 1'b0;
         end
         if (!nwmbp)
            regs[0] <= ibus_in;
         if (!nsave)
            shadow <= regs[0];
         nw_q <= nw;
         if (!nir_idx)
            idx_lat <= 1'b1;
         else if (t34)
            idx_lat <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mbu_param.sv
// Self-checking bench for mbu_param: directed scenarios plus random
// stimulus compared against a behavioural model of the bank unit.
module tb_mbu_param;

   logic       clk = 1'b0;
   logic       nreset, nfpram_rom, nwmbp, nrmbp, nwar;
   logic [1:0] waddr;
   logic       nir_idx, t34;
   logic [2:0] ir, io_addr;
   logic [7:0] ibus_in, db_in;
   logic [7:0] ibus_out, db_out, aext;
   logic       ibus_oe, db_oe, niombr, nr, nw;
   logic       nbinc, nsave, nrestore, nen, bovf;

   int errors = 0;
   int checks = 0;

   int m_reg [8];
   int m_shadow;
   bit m_nen, m_bovf, m_nwq, m_lat;

   mbu_param dut (
      .clk(clk), .nreset(nreset), .nfpram_rom(nfpram_rom),
      .nwmbp(nwmbp), .nrmbp(nrmbp), .nwar(nwar), .waddr(waddr),
      .nir_idx(nir_idx), .t34(t34), .ir(ir), .ibus_in(ibus_in),
      .ibus_out(ibus_out), .ibus_oe(ibus_oe), .niombr(niombr),
      .io_addr(io_addr), .nr(nr), .nw(nw), .db_in(db_in),
      .db_out(db_out), .db_oe(db_oe), .nbinc(nbinc), .nsave(nsave),
      .nrestore(nrestore), .aext(aext), .nen(nen), .bovf(bovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int sel_idx();
      if (!nrmbp) return 0;
      if (!nwar) begin
         if (m_lat && waddr == 2'd3) return int'(ir);
         return int'(waddr);
      end
      return int'(io_addr);
   endfunction

   function automatic int exp_aext();
      if (m_nen) return nfpram_rom ? 128 : 0;
      return m_reg[sel_idx()];
   endfunction

   // Advance the model by one rising edge using the current inputs.
   task automatic model_edge();
      int  nxt [8];
      int  ri, a;
      bit  io_wr, inc_ok;
      if (!nreset) begin
         foreach (m_reg[i]) m_reg[i] = 0;
         m_shadow = 0; m_nen = 1; m_bovf = 0; m_nwq = 1; m_lat = 0;
         return;
      end
      ri = sel_idx();
      a = int'(io_addr);
      io_wr = !niombr && !nw && m_nwq;
      nxt = m_reg;
      inc_ok = !nbinc;
      if (ri == 0 && (!nwmbp || !nrestore)) inc_ok = 0;
      if (io_wr && a == ri) inc_ok = 0;
      if (inc_ok) begin
         nxt[ri] = (m_reg[ri] + 1) % 256;
         m_bovf = (m_reg[ri] == 255);
      end
      if (!nrestore && nwmbp && !(io_wr && a == 0)) nxt[0] = m_shadow;
      if (io_wr && !(!nwmbp && a == 0)) nxt[a] = int'(db_in);
      if (!nwmbp) nxt[0] = int'(ibus_in);
      if (!nsave) m_shadow = m_reg[0];
      if (io_wr) m_nen = 0;
      if (!nir_idx) m_lat = 1;
      else if (t34) m_lat = 0;
      m_nwq = nw;
      m_reg = nxt;
   endtask

   task automatic check_all(input string tag);
      int e;
      e = exp_aext();
      chk({tag, ".aext"}, int'(aext), e);
      chk({tag, ".ibus"}, int'({ibus_oe, ibus_out}),
          ((nrmbp ? 0 : 1) << 8) | e);
      chk({tag, ".db"}, int'({db_oe, db_out}),
          (((!niombr && !nr) ? 1 : 0) << 8) | e);
      chk({tag, ".flags"}, int'({nen, bovf}),
          (int'(m_nen) << 1) | int'(m_bovf));
   endtask

   task automatic tick(input string tag);
      model_edge();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic io_write(input int a, input int d);
      niombr = 0; io_addr = 3'(a); db_in = 8'(d); nw = 0;
      tick("iow");
      nw = 1; niombr = 1;
      tick("iow_end");
   endtask

   initial begin
      nreset = 0; nfpram_rom = 0; nwmbp = 1; nrmbp = 1; nwar = 1;
      waddr = 0; nir_idx = 1; t34 = 0; ir = 0; ibus_in = 0;
      niombr = 1; io_addr = 0; nr = 1; nw = 1; db_in = 0;
      nbinc = 1; nsave = 1; nrestore = 1;
      foreach (m_reg[i]) m_reg[i] = 0;
      m_shadow = 0; m_nen = 1; m_bovf = 0; m_nwq = 1; m_lat = 0;
      #2;
      tick("rst"); tick("rst");
      chk("rst_aext0", int'(aext), 8'h00);
      nfpram_rom = 1; #1;
      chk("rst_aext80", int'(aext), 8'h80);
      chk("rst_nen", int'(nen), 1);
      chk("rst_oe", int'({ibus_oe, db_oe}), 0);
      check_all("rst_rom");

      // one write per held strobe
      nreset = 1;
      niombr = 0; io_addr = 0; db_in = 8'h42; nw = 0;
      tick("hold1");
      db_in = 8'h77;
      tick("hold2"); tick("hold3");
      chk("hold_aext", int'(aext), 8'h42);
      chk("hold_nen", int'(nen), 0);
      nw = 1; nr = 0; #1;
      chk("rd_db", int'({db_oe, db_out}), 9'h142);
      nr = 1; niombr = 1;
      tick("hold_end");

      // auto-index
      io_write(3, 8'h10);
      io_write(5, 8'h55);
      nir_idx = 0; tick("lat_set");
      nir_idx = 1; ir = 5; nwar = 0; waddr = 3; #1;
      chk("autoidx", int'(aext), 8'h55);
      t34 = 1; tick("t34");
      t34 = 0; #1;
      chk("autoidx_clr", int'(aext), 8'h10);
      nwar = 1;

      // increment with wrap
      io_write(2, 8'hFF);
      nwar = 0; waddr = 2;
      nbinc = 0; tick("inc1"); nbinc = 1;
      chk("inc_wrap", int'({bovf, aext}), 9'h100);
      nbinc = 0; tick("inc2"); nbinc = 1;
      chk("inc_next", int'({bovf, aext}), 9'h001);
      nwar = 1;

      // shadow save/restore
      nwmbp = 0; ibus_in = 8'h12; tick("mbp12");
      nwmbp = 1; nsave = 0; tick("save"); nsave = 1;
      nwmbp = 0; ibus_in = 8'h34; tick("mbp34"); nwmbp = 1;
      nrmbp = 0; #1;
      chk("mbp_rd34", int'({ibus_oe, ibus_out}), 9'h134);
      nrestore = 0; tick("restore"); nrestore = 1; #1;
      chk("restore", int'(aext), 8'h12);
      nrmbp = 1;

      // CU write beats I/O write, then reset mid-strobe
      nwmbp = 0; ibus_in = 8'hAA;
      niombr = 0; io_addr = 0; db_in = 8'hBB; nw = 0;
      tick("conflict"); nwmbp = 1; #1;
      chk("conflict", int'(aext), 8'hAA);
      nreset = 0; tick("rst_mid");
      chk("rst_mid_nen", int'({nen, bovf}), 2'b10);
      nreset = 1; nw = 1; niombr = 1;
      tick("rst_rel");
      chk("rst_rel_nen", int'(nen), 1);
      io_write(7, 8'h01);
      for (int i = 0; i < 7; i++) begin
         io_addr = 3'(i); #1;
         chk("rst_clear", int'(aext), 0);
      end

      // random traffic
      for (int n = 0; n < 400; n++) begin
         nreset   = ($urandom_range(0, 40) != 0);
         nfpram_rom = 1'($urandom);
         nwmbp    = ($urandom_range(0, 4) != 0);
         nrmbp    = ($urandom_range(0, 4) != 0);
         nwar     = ($urandom_range(0, 2) != 0);
         waddr    = 2'($urandom);
         nir_idx  = ($urandom_range(0, 5) != 0);
         t34      = ($urandom_range(0, 5) == 0);
         ir       = 3'($urandom);
         ibus_in  = 8'($urandom);
         niombr   = ($urandom_range(0, 2) == 0);
         io_addr  = 3'($urandom);
         nr       = 1'($urandom);
         nw       = ($urandom_range(0, 2) == 0);
         db_in    = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
         nbinc    = ($urandom_range(0, 2) != 0);
         nsave    = ($urandom_range(0, 4) != 0);
         nrestore = ($urandom_range(0, 4) != 0);
         #1;
         check_all("rnd_comb");
         tick("rnd");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
